alu_mc: RTL and testbench

Multi-cycle, parametrised execute unit and the successor of the two-lane combinational ALU. Executes the base integer ops (add/sub, logic, shifts, compares, pass-B) in one registered cycle. Adds iterative RV-M multiply and divide behind a valid/ready handshake. Sits between the decode/issue stage and writeback, and stalls issue while a long op is in flight.

---
 rtl/alu_pkg.sv | 59 +++++
 rtl/alu_base.sv | 37 +++
 rtl/alu_mc.sv | 165 ++++++++++++++++
 tb/tb_alu_mc.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcodes, FSM state encodings and decode helpers for the alu_mc execute unit.
// The optional divider is enabled with the ALU_DIV_EN macro.
package alu_pkg;

    typedef enum logic [4:0] {
        OP_ADD    = 5'd0,
        OP_SUB    = 5'd1,
        OP_AND    = 5'd2,
        OP_OR     = 5'd3,
        OP_XOR    = 5'd4,
        OP_SLL    = 5'd5,
        OP_SRL    = 5'd6,
        OP_SRA    = 5'd7,
        OP_SLT    = 5'd8,
        OP_SLTU   = 5'd9,
        OP_PASSB  = 5'd10,
        OP_MUL    = 5'd11,
        OP_MULH   = 5'd12,
        OP_MULHSU = 5'd13,
        OP_MULHU  = 5'd14,
        OP_DIV    = 5'd15,
        OP_DIVU   = 5'd16,
        OP_REM    = 5'd17,
        OP_REMU   = 5'd18
    } alu_op_e;

    typedef logic [2:0] alu_state_e;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_MUL  = 3'd1;
    localparam logic [2:0] ST_DIV  = 3'd2;
    localparam logic [2:0] ST_FIX  = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

    // Fill bits for the quotient on divide-by-zero and the remainder on signed overflow.
    localparam logic DIV0_Q_BIT = 1'b1;
    localparam logic OVF_R_BIT  = 1'b0;

    function automatic logic is_mul(input logic [4:0] op);
        return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU};
    endfunction

    function automatic logic is_div(input logic [4:0] op);
        return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    endfunction

    function automatic logic is_rem(input logic [4:0] op);
        return op inside {OP_REM, OP_REMU};
    endfunction

    function automatic logic a_signed(input logic [4:0] op);
        return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    endfunction

    function automatic logic b_signed(input logic [4:0] op);
        return op inside {OP_MULH, OP_DIV, OP_REM};
    endfunction

endpackage

// File: rtl/alu_base.sv
// Single-cycle combinational integer ops; any other opcode yields zero and flags unk.
module alu_base
    import alu_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int SHAMT_W = $clog2(XLEN)
) (
    input  logic [4:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] y,
    output logic            unk
);

    logic [SHAMT_W-1:0] shamt;
    assign shamt = b[SHAMT_W-1:0];

    always_comb begin
        y   = '0;
        unk = 1'b0;
        case (op)
            OP_ADD:   y = a + b;
            OP_SUB:   y = a - b;
            OP_AND:   y = a & b;
            OP_OR:    y = a | b;
            OP_XOR:   y = a ^ b;
            OP_SLL:   y = a << shamt;
            OP_SRL:   y = a >> shamt;
            OP_SRA:   y = $signed(a) >>> shamt;
            OP_SLT:   y = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
            OP_SLTU:  y = {{(XLEN-1){1'b0}}, a < b};
            OP_PASSB: y = b;
            default:  unk = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle execute unit: registered base ops plus iterative RV-M multiply/divide.
// Divider hardware is present only when ALU_DIV_EN is defined.
module alu_mc
    import alu_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int SHAMT_W = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            kill,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            op_err,
    output logic            busy
);

    alu_state_e         state_q;
    logic [4:0]         op_q;
    logic [XLEN-1:0]    mc_q, hi_q, lo_q;
    logic [SHAMT_W-1:0] cnt_q;
    logic               neg_q;
    logic [XLEN-1:0]    base_y;
    logic               base_unk;
    logic               accept;
    logic               sa, sb;
    logic [XLEN-1:0]    mag_a, mag_b;
    logic [XLEN:0]      mul_sum;
    logic [2*XLEN-1:0]  prod;
    logic [XLEN-1:0]    fix_y;

    alu_base #(.XLEN(XLEN), .SHAMT_W(SHAMT_W)) u_base (
        .op  (op),
        .a   (a),
        .b   (b),
        .y   (base_y),
        .unk (base_unk)
    );

    assign in_ready  = (state_q == ST_IDLE) | ((state_q == ST_DONE) & out_ready);
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q == ST_MUL) | (state_q == ST_DIV);
    assign accept    = in_valid & in_ready;

    assign sa    = a_signed(op) & a[XLEN-1];
    assign sb    = b_signed(op) & b[XLEN-1];
    assign mag_a = sa ? -a : a;
    assign mag_b = sb ? -b : b;

    // Multiplier in lo_q is consumed LSB first while the partial sum shifts down into it.
    assign mul_sum = {1'b0, hi_q} + {1'b0, mc_q & {XLEN{lo_q[0]}}};

`ifdef ALU_DIV_EN
    logic [XLEN-1:0] a_q, b_q;
    logic            rneg_q;
    logic [XLEN:0]   div_sh, div_diff;
    logic [XLEN-1:0] quo, rem;

    assign div_sh   = {hi_q, lo_q[XLEN-1]};
    assign div_diff = div_sh - {1'b0, mc_q};
`endif

    always_comb begin
        prod  = neg_q ? -{hi_q, lo_q} : {hi_q, lo_q};
        fix_y = (op_q == OP_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
`ifdef ALU_DIV_EN
        quo = neg_q  ? -lo_q : lo_q;
        rem = rneg_q ? -hi_q : hi_q;
        if (b_q == '0) begin
            quo = {XLEN{DIV0_Q_BIT}};
            rem = a_q;
        end else if (b_signed(op_q) && a_q == {1'b1, {(XLEN-1){1'b0}}} && b_q == '1) begin
            quo = a_q;
            rem = {XLEN{OVF_R_BIT}};
        end
        if (is_div(op_q))
            fix_y = is_rem(op_q) ? rem : quo;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            op_q    <= '0;
            mc_q    <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            cnt_q   <= '0;
            neg_q   <= 1'b0;
            result  <= '0;
            op_err  <= 1'b0;
`ifdef ALU_DIV_EN
            a_q     <= '0;
            b_q     <= '0;
            rneg_q  <= 1'b0;
`endif
        end else if (kill) begin
            state_q <= ST_IDLE;
        end else begin
            case (state_q)
                ST_MUL: begin
                    {hi_q, lo_q} <= {mul_sum, lo_q[XLEN-1:1]};
                    cnt_q        <= cnt_q + 1'b1;
                    if (cnt_q == SHAMT_W'(XLEN-1)) state_q <= ST_FIX;
                end
`ifdef ALU_DIV_EN
                ST_DIV: begin
                    // Restoring step: keep the trial difference only when it did not borrow.
                    if (!div_diff[XLEN]) begin
                        hi_q <= div_diff[XLEN-1:0];
                        lo_q <= {lo_q[XLEN-2:0], 1'b1};
                    end else begin
                        hi_q <= div_sh[XLEN-1:0];
                        lo_q <= {lo_q[XLEN-2:0], 1'b0};
                    end
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == SHAMT_W'(XLEN-1)) state_q <= ST_FIX;
                end
`endif
                ST_FIX: begin
                    result  <= fix_y;
                    op_err  <= 1'b0;
                    state_q <= ST_DONE;
                end
                ST_DONE: if (out_ready) state_q <= ST_IDLE;
                default: ;
            endcase

            if (accept) begin
                op_q  <= op;
                cnt_q <= '0;
                neg_q <= sa ^ sb;
`ifdef ALU_DIV_EN
                a_q    <= a;
                b_q    <= b;
                rneg_q <= sa;
`endif
                if (is_mul(op)) begin
                    state_q <= ST_MUL;
                    hi_q    <= '0;
                    lo_q    <= mag_b;
                    mc_q    <= mag_a;
`ifdef ALU_DIV_EN
                end else if (is_div(op)) begin
                    state_q <= ST_DIV;
                    hi_q    <= '0;
                    lo_q    <= mag_a;
                    mc_q    <= mag_b;
`endif
                end else begin
                    state_q <= ST_DONE;
                    result  <= base_y;
                    op_err  <= base_unk;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_mc.sv
// Directed scoreboard bench for alu_mc; division cases follow the ALU_DIV_EN build option.
module tb_alu_mc;
    import alu_pkg::*;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [4:0]      op = '0;
    logic [XLEN-1:0] a = '0;
    logic [XLEN-1:0] b = '0;
    logic            kill = 1'b0;
    logic            out_valid;
    logic            out_ready = 1'b1;
    logic [XLEN-1:0] result;
    logic            op_err;
    logic            busy;

    int checks = 0;
    int errors = 0;
    int busy_cnt = 0;
    logic [XLEN:0] sb_q[$];

    alu_mc #(.XLEN(XLEN)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .kill      (kill),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .op_err    (op_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (busy) busy_cnt <= busy_cnt + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called just after a rising edge; returns just after the accept edge.
    task automatic issue(input logic [4:0] o, input logic [XLEN-1:0] x, input logic [XLEN-1:0] y,
                         input logic [XLEN-1:0] er, input logic ee, input bit push);
        int t = 0;
        in_valid = 1'b1; op = o; a = x; b = y;
        @(negedge clk);
        while (!in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) chk("accept_timeout", 64'(t), 64'd0);
        if (push) sb_q.push_back({ee, er});
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic collect(input string tag, input int exp_lat);
        int lat = 1;
        logic [XLEN:0] e;
        @(negedge clk);
        while (!out_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        e = sb_q.pop_front();
        chk({tag, "_res"}, 64'(result), 64'(e[XLEN-1:0]));
        chk({tag, "_err"}, 64'(op_err), 64'(e[XLEN]));
        @(posedge clk); #1;
    endtask

    task automatic run(input string tag, input logic [4:0] o, input logic [XLEN-1:0] x,
                       input logic [XLEN-1:0] y, input logic [XLEN-1:0] er, input logic ee,
                       input int lat);
        issue(o, x, y, er, ee, 1'b1);
        collect(tag, lat);
    endtask

    initial begin
        int b0;
        int seen;
        logic [4:0] kop;

        #12;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_busy",      64'(busy),      64'd0);
        chk("rst_in_ready",  64'(in_ready),  64'd1);
        chk("rst_result",    64'(result),    64'd0);
        chk("rst_op_err",    64'(op_err),    64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        run("add_ovf", OP_ADD,   32'h7FFF_FFFF, 32'h1,          32'h8000_0000, 1'b0, 1);
        run("sra",     OP_SRA,   32'h8000_0000, 32'h21,         32'hC000_0000, 1'b0, 1);
        run("sub",     OP_SUB,   32'd5,         32'd7,          32'hFFFF_FFFE, 1'b0, 1);
        run("slt",     OP_SLT,   32'hFFFF_FFFF, 32'd1,          32'd1,         1'b0, 1);
        run("sltu",    OP_SLTU,  32'hFFFF_FFFF, 32'd1,          32'd0,         1'b0, 1);
        run("sll",     OP_SLL,   32'd1,         32'd31,         32'h8000_0000, 1'b0, 1);
        run("srl",     OP_SRL,   32'h8000_0000, 32'd4,          32'h0800_0000, 1'b0, 1);
        run("xor",     OP_XOR,   32'hF0F0_F0F0, 32'hFF00_FF00,  32'h0FF0_0FF0, 1'b0, 1);
        run("passb",   OP_PASSB, 32'h1234_5678, 32'hCAFE_F00D,  32'hCAFE_F00D, 1'b0, 1);
        run("undef",   5'd31,    32'h1,         32'h2,          32'h0,         1'b1, 1);

        b0 = busy_cnt;
        run("mulh",    OP_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0, 34);
        chk("mulh_busy_cycles", 64'(busy_cnt - b0), 64'd32);
        run("mulhu",   OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 34);
        run("mul_neg", OP_MUL,    32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFEB, 1'b0, 34);
        run("mulhsu",  OP_MULHSU, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 1'b0, 34);

`ifdef ALU_DIV_EN
        run("div_by0",  OP_DIV,  32'd7,         32'd0,         32'hFFFF_FFFF, 1'b0, 34);
        run("rem_by0",  OP_REM,  32'd7,         32'd0,         32'd7,         1'b0, 34);
        run("div_ovf",  OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 34);
        run("rem_ovf",  OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1'b0, 34);
        run("rem_neg",  OP_REM,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 1'b0, 34);
        run("div_neg",  OP_DIV,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 1'b0, 34);
        run("divu",     OP_DIVU, 32'd100,       32'd7,         32'd14,        1'b0, 34);
        run("remu",     OP_REMU, 32'd100,       32'd7,         32'd2,         1'b0, 34);
        kop = OP_DIV;
`else
        run("divu_off", OP_DIVU, 32'd9,         32'd3,         32'd0,         1'b1, 1);
        run("rem_off",  OP_REM,  32'd9,         32'd3,         32'd0,         1'b1, 1);
        kop = OP_MULHU;
`endif

        // Consumer stalls: result must hold, then a waiting ADD is taken on the release edge.
        out_ready = 1'b0;
        run("hold_first", OP_ADD, 32'd1, 32'd2, 32'd3, 1'b0, 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_result",   64'(result),   64'd3);
            chk("hold_in_ready", 64'(in_ready), 64'd0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        in_valid = 1'b1; op = OP_ADD; a = 32'd10; b = 32'd20;
        sb_q.push_back({1'b0, 32'd30});
        @(negedge clk);
        chk("release_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        collect("hold_next", 1);

        // Abort a long op partway through.
        issue(kop, 32'd100, 32'd3, 32'd0, 1'b0, 1'b0);
        repeat (10) @(posedge clk);
        #1 kill = 1'b1;
        @(posedge clk); #1;
        kill = 1'b0;
        @(negedge clk);
        chk("kill_in_ready", 64'(in_ready), 64'd1);
        chk("kill_busy",     64'(busy),     64'd0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("kill_no_valid", 64'(seen), 64'd0);
        @(posedge clk); #1;
        run("post_kill_sub", OP_SUB, 32'd5, 32'd7, 32'hFFFF_FFFE, 1'b0, 1);

        // Asynchronous reset in the middle of a multiply.
        issue(OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0);
        repeat (5) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_busy",      64'(busy),      64'd0);
        chk("arst_out_valid", 64'(out_valid), 64'd0);
        chk("arst_in_ready",  64'(in_ready),  64'd1);
        chk("arst_result",    64'(result),    64'd0);
        chk("arst_op_err",    64'(op_err),    64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("arst_no_valid", 64'(seen), 64'd0);
        @(posedge clk); #1;
        run("post_rst_and", OP_AND, 32'hFF00_FF00, 32'h0F0F_0F0F, 32'h0F00_0F00, 1'b0, 1);
        chk("sb_drained", 64'(sb_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
